// File: rtl/sudoku_pkg.sv
// Shared geometry, cell/unit indexing helpers and FSM state type for the
// full-house Sudoku solver.
//   Cells are numbered k = 0..80 row-major; units are numbered
//   0..8 rows, 9..17 columns, 18..26 boxes.
package sudoku_pkg;

  localparam int unsigned N_CELLS   = 81;
  localparam int unsigned CELL_W    = 4;
  localparam int unsigned GRID_W    = 324;
  localparam int unsigned DIGIT_SUM = 45;
  localparam int unsigned N_UNITS   = 27;
  localparam int unsigned UNIT_W    = 36;

  typedef enum logic [1:0] {
    IDLE,
    SOLVE,
    DONE
  } state_e;

  function automatic int unsigned cell_row(int unsigned k);
    return k / 9;
  endfunction

  function automatic int unsigned cell_col(int unsigned k);
    return k % 9;
  endfunction

  function automatic int unsigned cell_box(int unsigned k);
    return 3 * (k / 27) + (k % 9) / 3;
  endfunction

  // Cell index of the j-th member (j = 0..8) of unit u.
  function automatic int unsigned unit_cell(int unsigned u, int unsigned j);
    if (u < 9) begin
      return u * 9 + j;
    end else if (u < 18) begin
      return j * 9 + (u - 9);
    end else begin
      return (3 * ((u - 18) / 3) + j / 3) * 9 + 3 * ((u - 18) % 3) + j % 3;
    end
  endfunction

endpackage

// File: rtl/sudoku_unit_stat.sv
// Statistics for one Sudoku unit (row, column or box) of nine cells.
//   cells_i   : nine 4-bit cells, member 0 in bits [0:3] (bit 0 is its MSB)
//   zcnt_o    : number of empty (zero) cells in the unit
//   missing_o : 45 minus the 6-bit sum of the nonzero digits, truncated to 4 bits;
//               equals the missing digit when exactly one cell is empty
module sudoku_unit_stat
  import sudoku_pkg::*;
(
  input  logic [0:UNIT_W-1] cells_i,
  output logic [3:0]        zcnt_o,
  output logic [3:0]        missing_o
);

  logic [3:0] digit;
  logic [3:0] zcnt;
  logic [5:0] sum;

  always_comb begin
    digit = '0;
    zcnt  = '0;
    sum   = '0;
    for (int unsigned j = 0; j < 9; j++) begin
      digit = cells_i[CELL_W*j +: CELL_W];
      if (digit == 4'd0) begin
        zcnt = zcnt + 4'd1;
      end else begin
        sum = sum + 6'(digit);
      end
    end
  end

  assign zcnt_o    = zcnt;
  assign missing_o = 4'(6'(DIGIT_SUM) - sum);

endmodule

// File: rtl/solve_sudoku_fullhouse.sv
// Iterative 9x9 Sudoku solver: a unit with a single blank gets its missing digit.
//   clk          : rising-edge clock
//   rst          : synchronous active-low reset
//   start        : level request, sampled in IDLE to load sudoku_given
//   sudoku_given : packed puzzle [0:323], cell k at bits [4k:4k+3], 0 = empty
//   sudoku       : registered working/solved grid, same packing
//   completed    : registered, 1 when the grid has no empty cell
// Every SOLVE cycle all empty cells that sit in a unit with exactly one blank
// are written in parallel; the solver stops when full or when nothing fills.
module solve_sudoku_fullhouse
  import sudoku_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:GRID_W-1] sudoku_given,
  output logic [0:GRID_W-1] sudoku,
  output logic              completed
);

  state_e            state_q;
  logic [0:GRID_W-1] grid_q;
  logic [0:GRID_W-1] grid_d;
  logic              completed_q;

  logic [3:0]         zcnt    [N_UNITS];
  logic [3:0]         missing [N_UNITS];
  logic [N_CELLS-1:0] empty;
  logic [N_CELLS-1:0] fill_en;
  logic [6:0]         n_empty;
  logic               any_fill;

  // Unit statistics from the registered grid.
  for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
    logic [0:UNIT_W-1] ucells;
    for (genvar j = 0; j < 9; j++) begin : g_member
      assign ucells[CELL_W*j +: CELL_W] = grid_q[CELL_W*unit_cell(u, j) +: CELL_W];
    end
    sudoku_unit_stat u_stat (
      .cells_i   (ucells),
      .zcnt_o    (zcnt[u]),
      .missing_o (missing[u])
    );
  end

  // Per-cell fill mux: row beats column beats box when several units qualify.
  for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
    localparam int unsigned R = cell_row(k);
    localparam int unsigned C = 9 + cell_col(k);
    localparam int unsigned B = 18 + cell_box(k);

    logic [3:0] cur;
    logic       row_hit;
    logic       col_hit;
    logic       box_hit;

    assign cur        = grid_q[CELL_W*k +: CELL_W];
    assign empty[k]   = (cur == 4'd0);
    assign row_hit    = (zcnt[R] == 4'd1);
    assign col_hit    = (zcnt[C] == 4'd1);
    assign box_hit    = (zcnt[B] == 4'd1);
    assign fill_en[k] = empty[k] && (row_hit || col_hit || box_hit);

    assign grid_d[CELL_W*k +: CELL_W] = !fill_en[k] ? cur        :
                                        row_hit     ? missing[R] :
                                        col_hit     ? missing[C] :
                                                      missing[B];
  end

  always_comb begin
    n_empty = '0;
    for (int unsigned k = 0; k < N_CELLS; k++) begin
      n_empty = n_empty + 7'(empty[k]);
    end
  end

  assign any_fill = |fill_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      grid_q      <= '0;
      completed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            grid_q      <= sudoku_given;
            completed_q <= 1'b0;
            state_q     <= SOLVE;
          end
        end
        SOLVE: begin
          if (n_empty == 7'd0) begin
            completed_q <= 1'b1;
            state_q     <= DONE;
          end else if (!any_fill) begin
            state_q <= DONE;
          end else begin
            grid_q <= grid_d;
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sudoku    = grid_q;
  assign completed = completed_q;

endmodule

// File: tb/tb_solve_sudoku_fullhouse.sv
module tb_solve_sudoku_fullhouse;

  localparam logic [0:323] P1  = 324'h183950246950106078726380195300812000472695813010473529501239784230740651847501032;
  localparam logic [0:323] SOL = 324'h183957246954126378726384195395812467472695813618473529561239784239748651847561932;

  typedef int grid_t [81];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [0:323] sudoku_given;
  logic [0:323] sudoku;
  logic         completed;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  solve_sudoku_fullhouse dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sudoku_given (sudoku_given),
    .sudoku       (sudoku),
    .completed    (completed)
  );

  // ---------------- reference model (grid as int array) ----------------
  function automatic void unpack_grid(input logic [0:323] p, output grid_t g);
    logic [0:323] t;
    t = p;
    for (int k = 0; k < 81; k++) g[k] = int'(t[4*k +: 4]);
  endfunction

  function automatic logic [0:323] pack_grid(input grid_t g);
    logic [0:323] p;
    for (int k = 0; k < 81; k++) p[4*k +: 4] = 4'(g[k]);
    return p;
  endfunction

  // Cell index of member j of a unit: kind 0 = row, 1 = column, 2 = box.
  function automatic int member(input int kind, input int idx, input int j);
    if (kind == 0) return idx * 9 + j;
    if (kind == 1) return j * 9 + idx;
    return ((idx / 3) * 3 + j / 3) * 9 + (idx % 3) * 3 + j % 3;
  endfunction

  // Blank count of a unit and the digit 1..9 absent from it.
  function automatic void unit_info(input grid_t g, input int kind, input int idx,
                                    output int blanks, output int miss);
    bit seen [10];
    int v;
    blanks = 0;
    miss   = 0;
    for (int d = 0; d < 10; d++) seen[d] = 0;
    for (int j = 0; j < 9; j++) begin
      v = g[member(kind, idx, j)];
      if (v == 0) blanks++;
      else if (v <= 9) seen[v] = 1;
    end
    for (int d = 1; d <= 9; d++) if (!seen[d]) miss = d;
  endfunction

  function automatic int count_blank(input grid_t g);
    int n = 0;
    for (int k = 0; k < 81; k++) if (g[k] == 0) n++;
    return n;
  endfunction

  // One full-house wave computed from the old grid; returns number of fills.
  function automatic int model_step(input grid_t g, output grid_t n);
    int fills = 0;
    int idx, blanks, miss;
    bit done;
    n = g;
    for (int k = 0; k < 81; k++) begin
      if (g[k] == 0) begin
        done = 0;
        for (int kind = 0; kind < 3; kind++) begin
          if (!done) begin
            idx = (kind == 0) ? k / 9 : (kind == 1) ? k % 9 : (k / 27) * 3 + (k % 9) / 3;
            unit_info(g, kind, idx, blanks, miss);
            if (blanks == 1) begin
              n[k] = miss;
              fills++;
              done = 1;
            end
          end
        end
      end
    end
    return fills;
  endfunction

  // Load a puzzle and follow the solver wave by wave against the model.
  task automatic run_model_check(input logic [0:323] given, input string name,
                                 input bit keep_start);
    grid_t cur, nxt;
    int    fills;
    bit    fin;
    logic  exp_c;
    start = 1'b0;
    @(posedge clk); #1;
    sudoku_given = given;
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    checks++;
    if (sudoku !== given || completed !== 1'b0) begin
      failures++;
      $display("FAIL %s load: sudoku=%h completed=%b required sudoku=%h completed=0",
               name, sudoku, completed, given);
    end
    unpack_grid(given, cur);
    fin   = 0;
    exp_c = 1'b0;
    while (!fin) begin
      if (count_blank(cur) == 0) begin
        exp_c = 1'b1;
        fin   = 1;
      end else begin
        fills = model_step(cur, nxt);
        if (fills == 0) fin = 1;
        else cur = nxt;
      end
      @(posedge clk); #1;
      checks++;
      if (sudoku !== pack_grid(cur) || completed !== (fin ? exp_c : 1'b0)) begin
        failures++;
        $display("FAIL %s wave: sudoku=%h completed=%b required sudoku=%h completed=%b",
                 name, sudoku, completed, pack_grid(cur), fin ? exp_c : 1'b0);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (sudoku !== pack_grid(cur) || completed !== exp_c) begin
      failures++;
      $display("FAIL %s hold: sudoku=%h completed=%b required sudoku=%h completed=%b",
               name, sudoku, completed, pack_grid(cur), exp_c);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0;
    start = 1'b1;
    sudoku_given = SOL;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sudoku !== '0 || completed !== 1'b0) begin
      failures++;
      $display("FAIL reset: sudoku=%h completed=%b required all-zero and 0", sudoku, completed);
    end
    start = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_spec_puzzle;
    int n;
    start = 1'b0;
    @(posedge clk); #1;
    sudoku_given = P1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (completed !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (completed !== 1'b1) begin
      failures++;
      $display("FAIL spec_latency: completed=%b after %0d cycles, required 1 within 20", completed, n);
    end
    checks++;
    if (sudoku !== SOL) begin
      failures++;
      $display("FAIL spec_grid: sudoku=%h required %h", sudoku, SOL);
    end
    run_model_check(P1, "spec_model", 1'b0);
  endtask

  task automatic test_already_solved;
    run_model_check(SOL, "solved", 1'b0);
  endtask

  task automatic test_all_zero;
    run_model_check('0, "all_zero", 1'b0);
  endtask

  task automatic test_box_only;
    logic [0:323] p;
    p = SOL;
    p[0:3]     = 4'h0;   // r0c0: only blank in box 0
    p[16:19]   = 4'h0;   // r0c4: second blank in row 0
    p[144:147] = 4'h0;   // r4c0: second blank in column 0
    run_model_check(p, "box_only", 1'b0);
    checks++;
    if (sudoku[0:3] !== 4'h1) begin
      failures++;
      $display("FAIL box_only_cell0: got %h required 1", sudoku[0:3]);
    end
  endtask

  task automatic test_reset_mid_solve;
    start = 1'b0;
    @(posedge clk); #1;
    sudoku_given = P1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sudoku !== '0 || completed !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: sudoku=%h completed=%b required all-zero and 0", sudoku, completed);
    end
    rst = 1'b1;
    run_model_check(P1, "after_reset", 1'b0);
  endtask

  task automatic test_start_held;
    logic [0:323] p2;
    p2 = SOL;
    p2[40:43] = 4'h0;
    p2[200:203] = 4'h0;
    run_model_check(P1, "held_first", 1'b1);
    sudoku_given = p2;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sudoku !== SOL || completed !== 1'b1) begin
      failures++;
      $display("FAIL start_held: sudoku=%h completed=%b required %h and 1", sudoku, completed, SOL);
    end
    run_model_check(p2, "held_reload", 1'b0);
  endtask

  task automatic test_random;
    grid_t base, g;
    int perm [10];
    int t, r, pct;
    unpack_grid(SOL, base);
    for (int it = 0; it < 30; it++) begin
      for (int d = 0; d < 10; d++) perm[d] = d;
      for (int d = 9; d > 1; d--) begin
        r = 1 + int'($urandom_range(d - 1));
        t = perm[d]; perm[d] = perm[r]; perm[r] = t;
      end
      pct = 5 + int'($urandom_range(70));
      for (int k = 0; k < 81; k++) begin
        g[k] = (int'($urandom_range(99)) < pct) ? 0 : perm[base[k]];
      end
      run_model_check(pack_grid(g), $sformatf("random%0d", it), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    sudoku_given = '0;
    test_reset();
    test_spec_puzzle();
    test_already_solved();
    test_all_zero();
    test_box_only();
    test_reset_mid_solve();
    test_start_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
